// File: rtl/equiv_stim_gen.sv
// Seeded LFSR stimulus source and lock-step y_1/y_2 comparator for a two-DUT equivalence harness.
// Latency: wire* registered one edge after start; y for vector k is checked DUT_LATENCY cycles after it is issued.
// No backpressure: one vector per cycle while running; halts on first mismatch. Optional EQUIV_STIM_ASSERT_EN adds sim asserts.
module equiv_stim_gen #(
    parameter logic [31:0] SEED        = 32'hACE1_2B3D,
    parameter int          NUM_VECTORS = 1024,
    parameter int          DUT_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [15:0]        fail_index,
    output logic [78:0]        fail_vector,
    output logic [17:0]        wire0,
    output logic [16:0]        wire1,
    output logic signed [14:0] wire2,
    output logic signed [9:0]  wire3,
    output logic signed [18:0] wire4,
    input  logic [90:0]        y_1,
    input  logic [90:0]        y_2
);

    // A zero seed would lock the LFSR at zero forever
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int          TAP      = (DUT_LATENCY == 0) ? 0 : DUT_LATENCY - 1;
    localparam int          DEPTH    = TAP + 1;
    localparam logic [15:0] NV16     = 16'(NUM_VECTORS);
    localparam logic [15:0] LAST     = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAT4     = 4'(DUT_LATENCY);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_FAIL} state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // V = {L, ror(L,11), ror(L,23)} truncated to the 79 DUT input bits
    function automatic logic [78:0] make_vec(input logic [31:0] l);
        logic [95:0] full;
        full = {l, l[10:0], l[31:11], l[22:0], l[31:23]};
        return full[78:0];
    endfunction

    state_t       state_q, state_d;
    logic [31:0]  lfsr_q, lfsr_d;
    logic [15:0]  issue_q, issue_d;     // number of vectors issued so far
    logic [15:0]  chk_q, chk_d;         // index of the next vector to check
    logic [3:0]   run_cyc_q, run_cyc_d; // cycles since RUN entry, saturating at DUT_LATENCY
    logic [78:0]  vec_q, vec_d;
    logic [78:0]  hist_q [DEPTH];
    logic [78:0]  hist_d [DEPTH];
    logic         busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [15:0]  fidx_q, fidx_d;
    logic [78:0]  fvec_q, fvec_d;
    logic         chk_en, mismatch;
    logic [78:0]  chk_vec;

    // Next-state: issue, check, and FSM transitions
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        issue_d   = issue_q;
        chk_d     = chk_q;
        run_cyc_d = run_cyc_q;
        vec_d     = vec_q;
        busy_d    = busy_q;
        done_d    = done_q;
        fail_d    = fail_q;
        fidx_d    = fidx_q;
        fvec_d    = fvec_q;
        // history of wire* values; entry i is what was driven i+1 cycles ago
        hist_d[0] = vec_q;
        for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
        chk_vec  = (DUT_LATENCY == 0) ? vec_q : hist_q[TAP];
        chk_en   = busy_q && (run_cyc_q >= LAT4);
        mismatch = chk_en && (y_1 != y_2);

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    // vector 0 goes straight onto wire*, so the LFSR steps past SEED here
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    vec_d     = make_vec(SEED_EFF);
                    lfsr_d    = lfsr_next(SEED_EFF);
                    issue_d   = 16'd1;
                    chk_d     = 16'd0;
                    run_cyc_d = 4'd0;
                end
            end
            S_RUN, S_DRAIN: begin
                if (run_cyc_q < LAT4) run_cyc_d = run_cyc_q + 4'd1;
                if (mismatch) begin
                    // failure wins over any issue scheduled for this edge
                    state_d = S_FAIL;
                    busy_d  = 1'b0;
                    fail_d  = 1'b1;
                    fidx_d  = chk_q;
                    fvec_d  = chk_vec;
                end else begin
                    if (state_q == S_RUN) begin
                        if (issue_q < NV16) begin
                            vec_d   = make_vec(lfsr_q);
                            lfsr_d  = lfsr_next(lfsr_q);
                            issue_d = issue_q + 16'd1;
                        end else if (DUT_LATENCY != 0) begin
                            state_d = S_DRAIN;
                        end
                    end
                    if (chk_en) begin
                        chk_d = chk_q + 16'd1;
                        if (chk_q == LAST) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_EFF;
            issue_q   <= 16'd0;
            chk_q     <= 16'd0;
            run_cyc_q <= 4'd0;
            vec_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            fidx_q    <= 16'd0;
            fvec_q    <= '0;
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            issue_q   <= issue_d;
            chk_q     <= chk_d;
            run_cyc_q <= run_cyc_d;
            vec_q     <= vec_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            fidx_q    <= fidx_d;
            fvec_q    <= fvec_d;
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign fail_index  = fidx_q;
    assign fail_vector = fvec_q;
    assign wire0       = vec_q[17:0];
    assign wire1       = vec_q[34:18];
    assign wire2       = vec_q[49:35];
    assign wire3       = vec_q[59:50];
    assign wire4       = vec_q[78:60];

`ifdef EQUIV_STIM_ASSERT_EN
    // Simulation-only: flag mismatches and starts that arrive while busy
    always @(posedge clk) begin
        if (rst_n) begin
            if (chk_en) assert (y_1 == y_2);
            assert (!(start && busy_q));
        end
    end
`endif

endmodule

// File: tb/tb_equiv_stim_gen.sv
module tb_equiv_stim_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic [90:0] y1_a, y2_a, y1_b, y2_b;

    logic               busy_a, done_a, fail_a, busy_b, done_b, fail_b;
    logic [15:0]        fidx_a, fidx_b;
    logic [78:0]        fvec_a, fvec_b;
    logic [17:0]        w0_a, w0_b;
    logic [16:0]        w1_a, w1_b;
    logic signed [14:0] w2_a, w2_b;
    logic signed [9:0]  w3_a, w3_b;
    logic signed [18:0] w4_a, w4_b;
    logic [78:0]        wv_a, wv_b;

    assign wv_a = {w4_a, w3_a, w2_a, w1_a, w0_a};
    assign wv_b = {w4_b, w3_b, w2_b, w1_b, w0_b};

    equiv_stim_gen #(.NUM_VECTORS(16), .DUT_LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .busy(busy_a), .done(done_a), .fail(fail_a),
        .fail_index(fidx_a), .fail_vector(fvec_a),
        .wire0(w0_a), .wire1(w1_a), .wire2(w2_a), .wire3(w3_a), .wire4(w4_a),
        .y_1(y1_a), .y_2(y2_a)
    );

    equiv_stim_gen #(.NUM_VECTORS(16), .DUT_LATENCY(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .busy(busy_b), .done(done_b), .fail(fail_b),
        .fail_index(fidx_b), .fail_vector(fvec_b),
        .wire0(w0_b), .wire1(w1_b), .wire2(w2_b), .wire3(w3_b), .wire4(w4_b),
        .y_1(y1_b), .y_2(y2_b)
    );

    int errs   = 0;
    int checks = 0;
    logic [78:0] ev [16];

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [78:0] tb_vec(input logic [31:0] l);
        logic [95:0] f;
        f = {l, l[10:0], l[31:11], l[22:0], l[31:23]};
        return f[78:0];
    endfunction

    // Start a run on instance A and follow it to completion; optionally pulse start mid-run
    task automatic run_a(input int mid_start);
        int n;
        n = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        chk("a_done_clr", done_a, 1'b0);
        chk("a_v0_wire0", w0_a, 18'h27B59);
        chk("a_v0_wire1", w1_a, 17'h17095);
        for (int c = 0; c < 40; c++) begin
            if (!busy_a) break;
            chk($sformatf("a_wire_c%0d", c), wv_a, ev[(c < 16) ? c : 15]);
            start_a = (c == mid_start);
            n++;
            @(negedge clk);
        end
        start_a = 1'b0;
        chk("a_busy_len", n, 17);
        chk("a_done", done_a, 1'b1);
        chk("a_fail", fail_a, 1'b0);
        chk("a_wire_hold", wv_a, ev[15]);
    endtask

    // Start a run on instance B and corrupt y_2 during RUN cycle bad only
    task automatic run_b(input int bad, input int exp_idx);
        int n;
        n = 0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        chk("b_fail_clr", fail_b, 1'b0);
        chk("b_busy_on", busy_b, 1'b1);
        for (int c = 0; c < 40; c++) begin
            if (!busy_b) break;
            chk($sformatf("b_wire_c%0d", c), wv_b, ev[(c < 16) ? c : 15]);
            y2_b = y1_b ^ ((c == bad) ? 91'd1 : 91'd0);
            n++;
            @(negedge clk);
        end
        y2_b = y1_b;
        chk("b_busy_len", n, bad + 1);
        repeat (3) @(negedge clk);
        chk("b_fail", fail_b, 1'b1);
        chk("b_done", done_b, 1'b0);
        chk("b_busy", busy_b, 1'b0);
        chk("b_fail_index", fidx_b, exp_idx);
        chk("b_fail_vector", fvec_b, ev[exp_idx]);
        chk("b_wire_frozen", wv_b, ev[(bad < 16) ? bad : 15]);
    endtask

    initial begin
        logic [31:0] l;
        l = 32'hACE1_2B3D;
        for (int k = 0; k < 16; k++) begin
            ev[k] = tb_vec(l);
            l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
        end

        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        y1_a    = '0;
        y2_a    = '0;
        y1_b    = 91'h5A5_1234_ABCD_0F0F_3C3C;
        y2_b    = y1_b;
        #23 rst_n = 1'b1;

        // idle after reset release
        repeat (20) @(negedge clk);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_fail", fail_a, 1'b0);
        chk("rst_wires", wv_a, 79'd0);
        chk("rst_fidx", fidx_a, 16'd0);
        chk("rst_fvec", fvec_a, 79'd0);
        chk("rst_b_wires", wv_b, 79'd0);

        // passing runs: from IDLE, from DONE, and with an ignored mid-run start
        run_a(-1);
        run_a(-1);
        run_a(5);

        // asynchronous reset at RUN cycle 7
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", busy_a, 1'b1);
        chk("mid_wire", wv_a, ev[7]);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_done", done_a, 1'b0);
        chk("arst_fail", fail_a, 1'b0);
        chk("arst_wires", wv_a, 79'd0);
        chk("arst_fidx", fidx_a, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        run_a(-1);

        // mismatch on vector 5, then restart from FAIL with a mismatch on the final check
        run_b(7, 5);
        run_b(17, 15);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
